// File: rtl/vrf_pkg.sv
// Shared constants and types for the vector register file access controller.
package vrf_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;

    // Regfile direction encoding, also used for req_rw.
    localparam logic RF_WRITE = 1'b1;
    localparam logic RF_READ  = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } vrf_state_e;

endpackage

// File: rtl/vrf_rd_fifo.sv
// Read-return FIFO: data plus last flag, with occupancy count for credit checks.
module vrf_rd_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only alongside a pop.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage; contents are only observed while non-empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    overflow_chk : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("vrf_rd_fifo overflow");

endmodule

// File: rtl/vrf_access_ctrl.sv
// Sequencer driving a single-port vector regfile for 1..8 register groups.
// Writes stream in one word per cycle; reads are issued against credits so the
// return FIFO can always absorb every word still in flight.
module vrf_access_ctrl #(
    parameter int unsigned DATA_W     = vrf_pkg::DATA_W,
    parameter int unsigned ADDR_W     = vrf_pkg::ADDR_W,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_cnt,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              rf_en,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);
    import vrf_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_CREDIT = (CW + 1)'(FIFO_DEPTH);

    vrf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [2:0]        rem_q, rem_d;
    logic              rf_en_d;
    logic              rf_rw_d;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_data_in_d;
    logic              iss_last_q, iss_last_d;
    logic [READ_LAT-1:0] pipe_vld_q;
    logic [READ_LAT-1:0] pipe_last_q;
    logic [CW-1:0]     inflight_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W:0]   fifo_rdata;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;

    // Reads still in flight plus words already queued must fit in the FIFO.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_CREDIT;
    assign push      = pipe_vld_q[READ_LAT-1];
    assign pop       = rd_valid && rd_ready;

    // Next-state, request/write handshakes and next regfile command.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        rf_en_d      = 1'b0;
        rf_rw_d      = rf_rw;
        rf_addr_d    = rf_addr;
        rf_data_in_d = rf_data_in;
        iss_last_d   = 1'b0;
        issue        = 1'b0;
        req_ready    = 1'b0;
        wr_ready     = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    cur_d   = req_addr;
                    rem_d   = req_cnt;
                    state_d = (req_rw == RF_WRITE) ? StWrite : StRead;
                end
            end
            StWrite: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    rf_en_d      = 1'b1;
                    rf_rw_d      = RF_WRITE;
                    rf_addr_d    = cur_q;
                    rf_data_in_d = wr_data;
                    cur_d        = cur_q + 1'b1;
                    rem_d        = rem_q - 1'b1;
                    if (rem_q == 3'd0) begin
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    rf_en_d    = 1'b1;
                    rf_rw_d    = RF_READ;
                    rf_addr_d  = cur_q;
                    iss_last_d = (rem_q == 3'd0);
                    cur_d      = cur_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == 3'd0) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (inflight_q == '0 && fifo_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, group cursor and registered regfile command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            rem_q      <= '0;
            rf_en      <= 1'b0;
            rf_rw      <= 1'b0;
            rf_addr    <= '0;
            rf_data_in <= '0;
            iss_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            rf_en      <= rf_en_d;
            rf_rw      <= rf_rw_d;
            rf_addr    <= rf_addr_d;
            rf_data_in <= rf_data_in_d;
            iss_last_q <= iss_last_d;
        end
    end

    // Latency pipe: stage 0 captures the strobe as the regfile samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= rf_en && (rf_rw == RF_READ);
            pipe_last_q[0] <= iss_last_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    // In-flight count covers the registered strobe and every pipe stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(issue) - CW'(push);
        end
    end

    vrf_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({pipe_last_q[READ_LAT-1], rf_data_out}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head is masked while empty so stale entries never show on the port.
    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign rd_last  = !fifo_empty && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Scoreboard bench for vrf_access_ctrl with a behavioural regfile model.
module tb_vrf_access_ctrl;

    localparam int unsigned READ_LAT   = 1;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rw;
    logic [4:0]  req_addr;
    logic [2:0]  req_cnt;
    logic        wr_valid, wr_ready;
    logic [63:0] wr_data;
    logic        rd_valid, rd_ready, rd_last, busy;
    logic [63:0] rd_data;
    logic        rf_en, rf_rw;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data_in, rf_data_out;

    vrf_access_ctrl #(
        .DATA_W     (64),
        .ADDR_W     (5),
        .READ_LAT   (READ_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_cnt     (req_cnt),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .busy        (busy),
        .rf_en       (rf_en),
        .rf_rw       (rf_rw),
        .rf_addr     (rf_addr),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [63:0] data;
    } rf_exp_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } rd_exp_t;

    int          checks = 0;
    int          failures = 0;
    int          rf_pulses = 0;
    int          rd_issues = 0;
    int          rd_pops = 0;
    int          rd_mode = 0;
    rf_exp_t     exp_rf[$];
    rd_exp_t     exp_rd[$];
    logic [63:0] ref_mem [32];
    logic [63:0] wbuf [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single-port regfile: write on strobe, read data READ_LAT cycles after sampling.
    logic        rf_init = 1'b0;
    logic [63:0] rf_mem [32];
    logic [63:0] lat_pipe [READ_LAT];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= ref_mem[i];
        end else if (rf_en && rf_rw) begin
            rf_mem[rf_addr] <= rf_data_in;
        end
        lat_pipe[0] <= rf_mem[rf_addr];
        for (int i = 1; i < READ_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
    end
    assign rf_data_out = lat_pipe[READ_LAT-1];

    // Regfile-side monitor.
    initial forever begin
        @(negedge clk);
        if (!rst && rf_en) begin
            rf_pulses++;
            if (!rf_rw) rd_issues++;
            if (exp_rf.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rf_unexpected: got access rw=%0b addr=%0d, expected none",
                         rf_rw, rf_addr);
            end else begin
                rf_exp_t e;
                e = exp_rf.pop_front();
                check("rf_rw", 64'(rf_rw), 64'(e.rw));
                check("rf_addr", 64'(rf_addr), 64'(e.addr));
                if (e.rw) check("rf_data_in", rf_data_in, e.data);
            end
        end
    end

    // Read-return monitor.
    initial forever begin
        @(negedge clk);
        if (!rst && rd_valid && rd_ready) begin
            rd_pops++;
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got word %h, expected none", rd_data);
            end else begin
                rd_exp_t e;
                e = exp_rd.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_last", 64'(rd_last), 64'(e.last));
            end
        end
    end

    // Consumer: 0 always ready, 1 stalled, otherwise random.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'b0;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (busy || !req_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > limit) begin
                checks++;
                failures++;
                $display("FAIL %s: busy=%0b after %0d cycles, expected 0", name, busy, n);
                return;
            end
        end
    endtask

    // Issue one group; writes stream wbuf[0..cnt]. gap: 0 none, 1 alternate, 2 random.
    task automatic do_group(input logic rw, input logic [4:0] addr, input logic [2:0] cnt,
                            input int gap);
        int      n;
        rf_exp_t fe;
        rd_exp_t re;
        logic [4:0] a;
        n = 0;
        while (!req_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL req_wait: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
                return;
            end
        end
        for (int i = 0; i <= int'(cnt); i++) begin
            a = addr + 5'(i);
            fe.rw   = rw;
            fe.addr = a;
            fe.data = rw ? wbuf[i] : 64'h0;
            exp_rf.push_back(fe);
            if (rw) begin
                ref_mem[a] = wbuf[i];
            end else begin
                re.data = ref_mem[a];
                re.last = (i == int'(cnt));
                exp_rd.push_back(re);
            end
        end
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_cnt   = cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 5'($urandom);
        if (rw) begin
            for (int i = 0; i <= int'(cnt); i++) begin
                wr_valid = 1'b1;
                wr_data  = wbuf[i];
                n = 0;
                while (!wr_ready && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                @(posedge clk);
                #1;
                wr_valid = 1'b0;
                wr_data  = {$urandom, $urandom};
                if (gap == 1) wait_cycles(1);
                else if (gap == 2) wait_cycles($urandom_range(0, 2));
            end
        end
    endtask

    int base;
    int base_pop;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_cnt   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = {$urandom, $urandom};
        rf_init = 1'b1;
        wait_cycles(2);
        rf_init = 1'b0;

        // Reset values.
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_last", 64'(rd_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rf_en", 64'(rf_en), 64'd0);
        check("rst_rf_rw", 64'(rf_rw), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_rf_data_in", rf_data_in, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        wait_cycles(1);

        // Single write then read back.
        wbuf[0] = 64'hABCDEF0123456789;
        base = rf_pulses;
        do_group(1'b1, 5'd0, 3'd0, 0);
        wait_cycles(1);
        check("single_wr_pulses", 64'(rf_pulses - base), 64'd1);
        do_group(1'b0, 5'd0, 3'd0, 0);
        wait_idle(50, "single_rd_idle");

        // Group write/read of four registers.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h10 + 64'(i);
        do_group(1'b1, 5'd4, 3'd3, 0);
        do_group(1'b0, 5'd4, 3'd3, 0);
        wait_idle(50, "group_rd_idle");

        // Address wrap past register 31.
        for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
        do_group(1'b1, 5'd30, 3'd3, 0);
        do_group(1'b0, 5'd30, 3'd3, 0);
        wait_idle(50, "wrap_rd_idle");

        // Backpressure: issue must stall at FIFO_DEPTH strobes.
        rd_mode = 1;
        wait_cycles(2);
        base     = rd_issues;
        base_pop = rd_pops;
        do_group(1'b0, 5'd16, 3'd7, 0);
        wait_cycles(20);
        check("bp_issue_stall", 64'(rd_issues - base), 64'(FIFO_DEPTH));
        check("bp_rd_valid", 64'(rd_valid), 64'd1);
        check("bp_busy", 64'(busy), 64'd1);
        rd_mode = 0;
        wait_idle(100, "bp_idle");
        check("bp_total_issues", 64'(rd_issues - base), 64'd8);
        check("bp_total_pops", 64'(rd_pops - base_pop), 64'd8);

        // Write with wr_valid on alternate cycles: 4 words in 8 cycles.
        for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
        base = rf_pulses;
        do_group(1'b1, 5'd8, 3'd3, 1);
        check("gap_pulses", 64'(rf_pulses - base), 64'd4);
        check("gap_req_ready", 64'(req_ready), 64'd1);
        do_group(1'b0, 5'd8, 3'd3, 0);
        wait_idle(50, "gap_rd_idle");

        // Reset in the middle of a read after two issues.
        rd_mode = 0;
        base = rd_issues;
        do_group(1'b0, 5'd12, 3'd5, 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (rd_issues - base >= 2) break;
        end
        check("mid_rst_issues", 64'(rd_issues - base), 64'd2);
        rst = 1'b1;
        exp_rf.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_rf_en", 64'(rf_en), 64'd0);
        rst = 1'b0;
        wait_cycles(1);
        for (int i = 0; i < 2; i++) wbuf[i] = {$urandom, $urandom};
        do_group(1'b1, 5'd12, 3'd1, 0);
        do_group(1'b0, 5'd11, 3'd3, 0);
        wait_idle(50, "post_rst_idle");

        // Randomized groups with random write gaps and consumer stalls.
        rd_mode = 2;
        for (int k = 0; k < 16; k++) begin
            logic       rw;
            logic [4:0] a;
            logic [2:0] c;
            rw = 1'($urandom_range(0, 1));
            a  = 5'($urandom);
            c  = 3'($urandom);
            for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
            do_group(rw, a, c, 2);
            if (!rw) wait_idle(300, "rand_rd_idle");
        end
        rd_mode = 0;
        wait_idle(300, "final_idle");
        wait_cycles(3);
        check("final_rf_queue_empty", 64'(exp_rf.size()), 64'd0);
        check("final_rd_queue_empty", 64'(exp_rd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
